// File: rtl/arb_pkg.sv
// arb_pkg: shared types and helpers for shared_reg_arbiter and rr_pick.
//   arb_state_e : arbiter FSM state (ARB_IDLE, ARB_BUSY)
//   idx_w(n)    : bit width of an index into n requesters (minimum 1)
package arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick of the first set req bit at or after ptr, wrapping.
//   req  in  N_REQ  request bits
//   ptr  in  IW     scan start index (< N_REQ)
//   pick out N_REQ  one-hot winner, zero when req is zero
//   idx  out IW     index of the winner, zero when req is zero
module rr_pick import arb_pkg::*; #(
  parameter int N_REQ = 4,
  localparam int IW = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IW-1:0]    idx
);
  function automatic logic [IW-1:0] wrap(input logic [IW-1:0] p, input int i);
    return IW'((int'(p) + i) % N_REQ);
  endfunction
  logic found;
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[wrap(ptr, i)]) begin
        found = 1'b1;
        pick[wrap(ptr, i)] = 1'b1;
        idx = wrap(ptr, i);
      end
    end
  end
endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin ownership of one shared WIDTH-bit register among N_REQ requesters.
//   clk      in  1            clock
//   rst_n    in  1            asynchronous active-low reset
//   req      in  N_REQ        request level per requester, held for the whole ownership
//   we       in  N_REQ        write enable per requester, only the owner's is honoured
//   wdata    in  N_REQ*WIDTH  write data, requester i in [i*WIDTH +: WIDTH]
//   gnt      out N_REQ        one-hot grant or zero
//   owner    out IW           current owner index, valid while busy
//   busy     out 1            a grant is active
//   rdata    out WIDTH        shared register contents
//   to_pulse out 1            forced-release pulse (only with ARB_TIMEOUT_EN defined)
// Optional feature macro: ARB_TIMEOUT_EN bounds ownership to MAX_HOLD cycles.
module shared_reg_arbiter import arb_pkg::*; #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 15,
  localparam int IW = idx_w(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       we,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [IW-1:0]          owner,
  output logic                   busy,
  output logic [WIDTH-1:0]       rdata
`ifdef ARB_TIMEOUT_EN
 ,output logic                   to_pulse
`endif
);
  if (N_REQ < 2 || N_REQ > 16 || WIDTH < 1 || MAX_HOLD < 1) begin : g_bad_cfg
    $error("shared_reg_arbiter: parameter out of range");
  end
  arb_state_e state_q, state_d;
  logic [IW-1:0] ptr_q, owner_q, pick_idx, ptr_nxt;
  logic [N_REQ-1:0] gnt_q, pick;
  logic [WIDTH-1:0] reg_q;
  logic grant_w, release_w, wr_w, timeout_w;
  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .pick (pick),
    .idx  (pick_idx)
  );
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] cnt_q;
  // The release edge is the one at which the count would reach MAX_HOLD, so an owner holds exactly MAX_HOLD cycles.
  assign timeout_w = state_q == ARB_BUSY && req[owner_q] && cnt_q == CW'(MAX_HOLD - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (grant_w) cnt_q <= '0;
    else if (state_q == ARB_BUSY) cnt_q <= cnt_q + 1'b1;
  end
`else
  assign timeout_w = 1'b0;
`endif
  assign grant_w   = state_q == ARB_IDLE && |req;
  assign release_w = state_q == ARB_BUSY && (!req[owner_q] || timeout_w);
  assign wr_w      = state_q == ARB_BUSY && req[owner_q] && we[owner_q];
  assign ptr_nxt   = owner_q == IW'(N_REQ - 1) ? '0 : owner_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARB_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == ARB_IDLE ? (grant_w ? ARB_BUSY : ARB_IDLE)
                                  : (release_w ? ARB_IDLE : ARB_BUSY);
  end
  always_comb begin
    busy  = state_q == ARB_BUSY;
    gnt   = gnt_q;
    owner = owner_q;
    rdata = reg_q;
`ifdef ARB_TIMEOUT_EN
    to_pulse = timeout_w;
`endif
  end
  // ptr moves only on release so fairness follows the last owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      reg_q   <= '0;
    end else begin
      if (grant_w) begin
        gnt_q   <= pick;
        owner_q <= pick_idx;
      end else if (release_w) begin
        gnt_q <= '0;
        ptr_q <= ptr_nxt;
      end
      if (wr_w) reg_q <= wdata[owner_q*WIDTH +: WIDTH];
    end
  end
endmodule
